pipe_stage_hs: RTL and testbench

//  Parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) with valid/ready

---
 rtl/pipe_stage_hs.sv | 82 ++++++++
 tb/tb_pipe_stage_hs.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pipe_stage_hs.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush, and control-field squashing on bubbles.
module pipe_stage_hs #(
  parameter int CTRL_W = 3,
  parameter int DATA_W = 52,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic              v;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t m_q, s_q;
  logic   in_fire, m_load;

  assign in_fire   = in_valid & in_ready;
  assign m_load    = ~m_q.v | out_ready;
  assign out_valid = m_q.v;
  assign out_data  = m_q.data;
  assign out_ctrl  = m_q.v ? m_q.ctrl : '0;
  assign occupancy = 2'(m_q.v) + 2'(s_q.v);

  // Main entry: refills from skid first so order is preserved.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q <= '0;
    end else if (flush) begin
      m_q.v    <= 1'b0;
      m_q.ctrl <= '0;
    end else if (m_load) begin
      if (s_q.v) begin
        m_q <= s_q;
      end else begin
        m_q.v    <= in_fire;
        m_q.ctrl <= in_fire ? in_ctrl : '0;
        if (in_fire) m_q.data <= in_data;
      end
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      // in_ready is a pure register output: no comb path from out_ready.
      assign in_ready = ~s_q.v;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s_q <= '0;
        end else if (flush) begin
          s_q.v    <= 1'b0;
          s_q.ctrl <= '0;
        end else if (m_load && s_q.v) begin
          s_q.v    <= 1'b0;
          s_q.ctrl <= '0;
        end else if (!m_load && in_fire) begin
          s_q.v    <= 1'b1;
          s_q.ctrl <= in_ctrl;
          s_q.data <= in_data;
        end
      end
    end else begin : g_noskid
      assign in_ready = ~m_q.v | out_ready;
      assign s_q      = '0;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed bench for pipe_stage_hs: SKID=1 instance (u_dut) and SKID=0 instance (u_dut0).
module tb_pipe_stage_hs;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  in_ctrl, out_ctrl;
  logic [51:0] in_data, out_data;
  logic [1:0]  occupancy;

  logic        z_flush, z_in_valid, z_in_ready, z_out_valid, z_out_ready;
  logic [2:0]  z_in_ctrl, z_out_ctrl;
  logic [51:0] z_in_data, z_out_data;
  logic [1:0]  z_occupancy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_stage_hs #(.CTRL_W(3), .DATA_W(52), .SKID(1)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .occupancy(occupancy));

  pipe_stage_hs #(.CTRL_W(3), .DATA_W(52), .SKID(0)) u_dut0 (
    .clk(clk), .rst(rst), .flush(z_flush), .in_valid(z_in_valid), .in_ready(z_in_ready),
    .in_ctrl(z_in_ctrl), .in_data(z_in_data), .out_valid(z_out_valid), .out_ready(z_out_ready),
    .out_ctrl(z_out_ctrl), .out_data(z_out_data), .occupancy(z_occupancy));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [2:0] c, input logic [51:0] d, input logic ordy);
    in_valid = v; in_ctrl = c; in_data = d; out_ready = ordy;
    #1;
  endtask

  task automatic chk_head(input string tag, input logic v, input logic [2:0] c,
                          input logic [51:0] d, input logic [1:0] occ);
    chk({tag, "_valid"}, 64'(out_valid), 64'(v));
    chk({tag, "_ctrl"},  64'(out_ctrl),  64'(c));
    chk({tag, "_data"},  64'(out_data),  64'(d));
    chk({tag, "_occ"},   64'(occupancy), 64'(occ));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
    z_flush = 1'b0; z_in_valid = 1'b0; z_in_ctrl = '0; z_in_data = '0; z_out_ready = 1'b0;
    cyc(); cyc(); #1;
    chk_head("rst_init", 1'b0, 3'd0, 52'd0, 2'd0);
    chk("rst_init_in_ready", 64'(in_ready), 64'd1);
    chk("rst_init_z_in_ready", 64'(z_in_ready), 64'd1);
    chk("rst_init_z_occ", 64'(z_occupancy), 64'd0);
    rst = 1'b0;
    cyc();

    // Streaming: 8 payloads, one per cycle, 1-cycle latency
    for (int k = 0; k <= 8; k++) begin
      drv(k < 8, 3'b101, 52'(k), 1'b1);
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      if (k == 0) chk("stream_first_valid", 64'(out_valid), 64'd0);
      else        chk_head($sformatf("stream%0d", k - 1), 1'b1, 3'b101, 52'(k - 1), 2'd1);
      cyc();
    end

    // Bubbles: in_ctrl=111 without in_valid never reaches out_ctrl; data held
    for (int k = 0; k < 3; k++) begin
      drv(1'b0, 3'b111, 52'hBAD, 1'b1);
      chk_head("bubble", 1'b0, 3'd0, 52'd7, 2'd0);
      cyc();
    end

    // Backpressure: A to M, B to S, C held upstream
    drv(1'b1, 3'd1, 52'hA, 1'b0); chk("bp_a_in_ready", 64'(in_ready), 64'd1); cyc();
    drv(1'b1, 3'd2, 52'hB, 1'b0); chk("bp_b_in_ready", 64'(in_ready), 64'd1);
    chk_head("bp_a_head", 1'b1, 3'd1, 52'hA, 2'd1); cyc();
    drv(1'b1, 3'd3, 52'hC, 1'b0); chk("bp_full_in_ready", 64'(in_ready), 64'd0);
    chk_head("bp_full", 1'b1, 3'd1, 52'hA, 2'd2); cyc();
    drv(1'b1, 3'd3, 52'hC, 1'b0); chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
    chk_head("bp_hold", 1'b1, 3'd1, 52'hA, 2'd2); cyc();
    drv(1'b1, 3'd3, 52'hC, 1'b1); chk("bp_rel_in_ready", 64'(in_ready), 64'd0);
    chk_head("bp_rel_a", 1'b1, 3'd1, 52'hA, 2'd2); cyc();
    drv(1'b1, 3'd3, 52'hC, 1'b1); chk("bp_rel_b_in_ready", 64'(in_ready), 64'd1);
    chk_head("bp_rel_b", 1'b1, 3'd2, 52'hB, 2'd1); cyc();
    drv(1'b0, 3'd0, 52'h0, 1'b1);
    chk_head("bp_rel_c", 1'b1, 3'd3, 52'hC, 2'd1); cyc();
    drv(1'b0, 3'd0, 52'h0, 1'b1);
    chk_head("bp_empty", 1'b0, 3'd0, 52'hC, 2'd0); cyc();

    // Flush with M and S full, in_valid asserted
    drv(1'b1, 3'd4, 52'h1D, 1'b0); cyc();
    drv(1'b1, 3'd6, 52'h1E, 1'b0); cyc();
    drv(1'b1, 3'd7, 52'h1F, 1'b0);
    chk_head("fl_full", 1'b1, 3'd4, 52'h1D, 2'd2);
    flush = 1'b1; cyc();
    flush = 1'b0; drv(1'b0, 3'd0, 52'h0, 1'b1);
    chk_head("fl_full_after", 1'b0, 3'd0, 52'h1D, 2'd0);
    chk("fl_full_in_ready", 64'(in_ready), 64'd1); cyc();
    drv(1'b0, 3'd0, 52'h0, 1'b1);
    chk_head("fl_full_quiet", 1'b0, 3'd0, 52'h1D, 2'd0); cyc();

    // Flush with M full and an in_fire in the same cycle: incoming dropped
    drv(1'b1, 3'd7, 52'h20, 1'b0); cyc();
    drv(1'b1, 3'd5, 52'h21, 1'b0); flush = 1'b1;
    chk("fl_fire_in_ready", 64'(in_ready), 64'd1);
    chk_head("fl_fire_pre", 1'b1, 3'd7, 52'h20, 2'd1); cyc();
    flush = 1'b0; drv(1'b0, 3'd0, 52'h0, 1'b1);
    chk_head("fl_fire_after", 1'b0, 3'd0, 52'h20, 2'd0); cyc();
    drv(1'b0, 3'd0, 52'h0, 1'b1);
    chk_head("fl_fire_quiet", 1'b0, 3'd0, 52'h20, 2'd0); cyc();

    // Asynchronous reset mid-stream with M and S full
    drv(1'b1, 3'd2, 52'h40, 1'b0); cyc();
    drv(1'b1, 3'd3, 52'h41, 1'b0); cyc();
    drv(1'b1, 3'd1, 52'h42, 1'b0);
    chk_head("ar_full", 1'b1, 3'd2, 52'h40, 2'd2);
    rst = 1'b1; #1;
    chk_head("ar_async", 1'b0, 3'd0, 52'h0, 2'd0);
    chk("ar_in_ready", 64'(in_ready), 64'd1);
    cyc();
    rst = 1'b0; drv(1'b0, 3'd0, 52'h0, 1'b0); cyc();

    // SKID=0: combinational in_ready, replace-on-fire
    z_in_valid = 1'b1; z_in_ctrl = 3'd5; z_in_data = 52'h30; z_out_ready = 1'b0; #1;
    chk("s0_empty_in_ready", 64'(z_in_ready), 64'd1); cyc();
    z_in_data = 52'h31; z_in_ctrl = 3'd6; #1;
    chk("s0_full_in_ready", 64'(z_in_ready), 64'd0);
    chk("s0_full_data", 64'(z_out_data), 64'h30);
    chk("s0_full_occ", 64'(z_occupancy), 64'd1); cyc();
    z_out_ready = 1'b1; #1;
    chk("s0_repl_in_ready", 64'(z_in_ready), 64'd1);
    chk("s0_repl_pre_data", 64'(z_out_data), 64'h30);
    chk("s0_repl_pre_ctrl", 64'(z_out_ctrl), 64'd5); cyc();
    z_in_valid = 1'b0; z_out_ready = 1'b0; #1;
    chk("s0_repl_valid", 64'(z_out_valid), 64'd1);
    chk("s0_repl_data", 64'(z_out_data), 64'h31);
    chk("s0_repl_ctrl", 64'(z_out_ctrl), 64'd6);
    chk("s0_repl_occ", 64'(z_occupancy), 64'd1); cyc();
    z_out_ready = 1'b1; #1; cyc();
    z_in_ctrl = 3'd7; #1;
    chk("s0_drain_valid", 64'(z_out_valid), 64'd0);
    chk("s0_drain_ctrl", 64'(z_out_ctrl), 64'd0);
    chk("s0_drain_occ", 64'(z_occupancy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
